// File: rtl/spi_reg_bank.sv
// Command/register layer behind an SPI byte slave: the first byte of each SSEL frame
// is a command {rw, ainc, addr[5:0]}; the bytes after it read or write an 8-bit register file.
module spi_reg_bank #(
  parameter int         NREGS   = 16,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SSEL,
  input  logic [7:0]         rx,
  input  logic               byte_received,
  output logic [7:0]         tx,
  output logic [8*NREGS-1:0] regs,
  output logic               wr_strobe,
  output logic [5:0]         wr_addr,
  output logic               addr_err,
  output logic               state_dbg
);

  typedef enum logic {CMD = 1'b0, DATA = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       ssel_meta_q, ssel_sync_q;
  logic [5:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic       ainc_q, ainc_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];
  logic       wr_strobe_q, wr_strobe_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic       addr_err_q, addr_err_d;
  logic       sel_active;
  logic [5:0] rd_addr;

  function automatic logic in_range(input logic [5:0] a);
    return {1'b0, a} < 7'(NREGS);
  endfunction

  function automatic logic [5:0] next_addr(input logic [5:0] a);
    if (!in_range(a) || ({1'b0, a} == 7'(NREGS - 1))) return 6'd0;
    return a + 6'd1;
  endfunction

  assign sel_active = ~ssel_sync_q;

  // Valid handshake: the slave holds rx valid only while byte_received is high; tx is
  // a registered byte that stays put until the next accepted byte or the frame ends.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    ainc_d      = ainc_q;
    tx_d        = tx_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    addr_err_d  = 1'b0;
    rd_addr     = 6'd0;
    if (!sel_active) begin
      state_d = CMD;
      tx_d    = ID_BYTE;
    end else if (byte_received) begin
      if (state_q == CMD) begin
        rw_d    = rx[7];
        ainc_d  = rx[6];
        addr_d  = rx[5:0];
        state_d = DATA;
        tx_d    = 8'h00;
        if (rx[7]) begin
          rd_addr = rx[5:0];
          if (in_range(rd_addr)) begin
            for (int k = 0; k < NREGS; k++)
              if (rd_addr == 6'(k)) tx_d = regs_q[k];
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end else if (!rw_q) begin
        tx_d = 8'h00;
        if (in_range(addr_q)) begin
          for (int k = 0; k < NREGS; k++)
            if (addr_q == 6'(k)) regs_d[k] = rx;
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
        end else begin
          addr_err_d = 1'b1;
        end
        if (ainc_q) addr_d = next_addr(addr_q);
      end else begin
        // Reads pre-load the byte the master will clock out during the next slot.
        rd_addr = ainc_q ? next_addr(addr_q) : addr_q;
        addr_d  = rd_addr;
        tx_d    = 8'h00;
        if (in_range(rd_addr)) begin
          for (int k = 0; k < NREGS; k++)
            if (rd_addr == 6'(k)) tx_d = regs_q[k];
        end else begin
          addr_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_meta_q <= 1'b1;
      ssel_sync_q <= 1'b1;
      state_q     <= CMD;
      addr_q      <= 6'd0;
      rw_q        <= 1'b0;
      ainc_q      <= 1'b0;
      tx_q        <= ID_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      addr_err_q  <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= 8'h00;
    end else begin
      ssel_meta_q <= SSEL;
      ssel_sync_q <= ssel_meta_q;
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      ainc_q      <= ainc_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      addr_err_q  <= addr_err_d;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NREGS; k++) regs[8*k +: 8] = regs_q[k];
  end

  assign tx        = tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign addr_err  = addr_err_q;
  assign state_dbg = state_q;

endmodule
